// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges per-stage stall requests, converts MEM-stage exceptions
// into a single-cycle flush with restart PC, and keeps stall statistics.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int unsigned FLUSH_HOLD  = 2,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;
  localparam logic [2:0] HOLD_LAST = 3'((FLUSH_HOLD == 0) ? 0 : FLUSH_HOLD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  logic [1:0]    state_q, state_d;
  logic [31:0]   exc_q, exc_d;
  logic [31:0]   epc_q, epc_d;
  logic [2:0]    hold_q, hold_d;
  logic [CW-1:0] cons_q, cons_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          timeout_q, timeout_d;

  logic [5:0]    stall_req_c;
  logic [5:0]    stall_c;
  logic          flush_c;
  logic [31:0]   new_pc_c;

  // Fixed-priority merge: the deepest requesting stage freezes everything upstream.
  always_comb begin
    stall_req_c = STALL_NONE;
    if (stallreq_mem)     stall_req_c = STALL_MEM;
    else if (stallreq_ex) stall_req_c = STALL_EX;
    else if (stallreq_id) stall_req_c = STALL_ID;
    else if (stallreq_if) stall_req_c = STALL_IF;
  end

  // Sequencer: next state plus zero-latency stall/flush/new_pc.
  always_comb begin
    state_d  = state_q;
    exc_d    = exc_q;
    epc_d    = epc_q;
    hold_d   = hold_q;
    stall_c  = stall_req_c;
    flush_c  = 1'b0;
    new_pc_c = 32'h0;

    case (state_q)
      IDLE: begin
        if (excepttype_i != 32'h0) begin
          if (stallreq_mem) begin
            stall_c = STALL_MEM;
            exc_d   = excepttype_i;
            epc_d   = cp0_epc_i;
            state_d = DRAIN;
          end else begin
            stall_c  = STALL_NONE;
            flush_c  = 1'b1;
            new_pc_c = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            hold_d   = 3'd0;
            state_d  = (FLUSH_HOLD == 0) ? IDLE : HOLD;
          end
        end
      end

      DRAIN: begin
        if (stallreq_mem) begin
          stall_c = STALL_MEM;
        end else begin
          stall_c  = STALL_NONE;
          flush_c  = 1'b1;
          new_pc_c = (exc_q == EXC_ERET) ? epc_q : EXC_VECTOR;
          hold_d   = 3'd0;
          state_d  = (FLUSH_HOLD == 0) ? IDLE : HOLD;
        end
      end

      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = 3'd0;
          state_d = IDLE;
        end else begin
          hold_d = 3'(hold_q + 3'd1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Statistics: saturating total, saturating run length, sticky timeout.
  always_comb begin
    cycles_d  = cycles_q;
    cons_d    = cons_q;
    timeout_d = timeout_q;
    if (stall_c[0]) begin
      if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
      if (cons_q != LIMIT)           cons_d   = CW'(cons_q + CW'(1));
    end else begin
      cons_d = '0;
    end
    if (cons_d == LIMIT) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      exc_q     <= 32'h0;
      epc_q     <= 32'h0;
      hold_q    <= 3'd0;
      cons_q    <= '0;
      cycles_q  <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exc_q     <= exc_d;
      epc_q     <= epc_d;
      hold_q    <= hold_d;
      cons_q    <= cons_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
    end
  end

  // Control outputs are forced quiet while reset is asserted.
  assign stall         = rst ? STALL_NONE : stall_c;
  assign flush         = rst ? 1'b0 : flush_c;
  assign new_pc        = rst ? 32'h0 : new_pc_c;
  assign stall_cycles  = cycles_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl (STALL_LIMIT reduced to 8).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  pipe_ctrl #(.EXC_VECTOR(VEC), .FLUSH_HOLD(2), .STALL_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;     // {mem, ex, id, if}
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [31:0] e_cyc;
    logic        e_to;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic [3:0] req, logic [31:0] exc, logic [31:0] epc,
                              logic [5:0] s, logic f, logic [31:0] pc, logic [31:0] cyc);
    vec_t v;
    v.req = req; v.exc = exc; v.epc = epc;
    v.e_stall = s; v.e_flush = f; v.e_pc = pc; v.e_cyc = cyc; v.e_to = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excepttype_i = exc;
    cp0_epc_i    = epc;
  endtask

  initial begin
    // req bits: {mem, ex, id, if}
    vecs[0]  = mk(4'b0010, 32'h0, 32'h0,        6'b000111, 1'b0, 32'h0,        32'd0);
    vecs[1]  = mk(4'b0010, 32'h0, 32'h0,        6'b000111, 1'b0, 32'h0,        32'd1);
    vecs[2]  = mk(4'b0010, 32'h0, 32'h0,        6'b000111, 1'b0, 32'h0,        32'd2);
    vecs[3]  = mk(4'b0110, 32'h0, 32'h0,        6'b001111, 1'b0, 32'h0,        32'd3);
    vecs[4]  = mk(4'b0000, 32'h0, 32'h0,        6'b000000, 1'b0, 32'h0,        32'd4);
    vecs[5]  = mk(4'b0000, 32'h1, 32'h0,        6'b000000, 1'b1, VEC,          32'd4);
    vecs[6]  = mk(4'b0010, 32'h5, 32'h0,        6'b000111, 1'b0, 32'h0,        32'd4);
    vecs[7]  = mk(4'b0000, 32'h5, 32'h0,        6'b000000, 1'b0, 32'h0,        32'd5);
    vecs[8]  = mk(4'b0000, 32'hE, 32'h80001000, 6'b000000, 1'b1, 32'h80001000, 32'd5);
    vecs[9]  = mk(4'b0000, 32'h0, 32'h0,        6'b000000, 1'b0, 32'h0,        32'd5);
    vecs[10] = mk(4'b0000, 32'h0, 32'h0,        6'b000000, 1'b0, 32'h0,        32'd5);
    vecs[11] = mk(4'b1000, 32'h4, 32'h12345678, 6'b011111, 1'b0, 32'h0,        32'd5);
    vecs[12] = mk(4'b1000, 32'hE, 32'h0BAD0000, 6'b011111, 1'b0, 32'h0,        32'd6);
    vecs[13] = mk(4'b1000, 32'h0, 32'h0,        6'b011111, 1'b0, 32'h0,        32'd7);
    vecs[14] = mk(4'b1000, 32'h0, 32'h0,        6'b011111, 1'b0, 32'h0,        32'd8);
    vecs[15] = mk(4'b1000, 32'h0, 32'h0,        6'b011111, 1'b0, 32'h0,        32'd9);
    vecs[16] = mk(4'b0000, 32'h0, 32'h0,        6'b000000, 1'b1, VEC,          32'd10);
    vecs[17] = mk(4'b0100, 32'h0, 32'h0,        6'b001111, 1'b0, 32'h0,        32'd10);
    vecs[18] = mk(4'b0000, 32'h0, 32'h0,        6'b000000, 1'b0, 32'h0,        32'd11);
    vecs[19] = mk(4'b0001, 32'h2, 32'h0,        6'b000000, 1'b1, VEC,          32'd11);
    vecs[20] = mk(4'b0001, 32'h0, 32'h0,        6'b000011, 1'b0, 32'h0,        32'd11);
    vecs[21] = mk(4'b1001, 32'h0, 32'h0,        6'b011111, 1'b0, 32'h0,        32'd12);
    vecs[22] = mk(4'b0000, 32'h0, 32'h0,        6'b000000, 1'b0, 32'h0,        32'd13);

    // Reset with busy inputs: control outputs must stay quiet.
    rst = 1'b1;
    drive(4'b1111, 32'h1, 32'h0);
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_stall",  32'(stall),  32'h0);
    chk("rst_flush",  32'(flush),  32'h0);
    chk("rst_new_pc", new_pc,      32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 32'h0, 32'h0);
    #1;
    chk("init_cycles",  stall_cycles,          32'h0);
    chk("init_timeout", 32'(stall_timeout),    32'h0);
    chk("init_stall",   32'(stall),            32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].exc, vecs[i].epc);
      #1;
      chk($sformatf("v%0d_stall", i),   32'(stall),         32'(vecs[i].e_stall));
      chk($sformatf("v%0d_flush", i),   32'(flush),         32'(vecs[i].e_flush));
      chk($sformatf("v%0d_new_pc", i),  new_pc,             vecs[i].e_pc);
      chk($sformatf("v%0d_cycles", i),  stall_cycles,       vecs[i].e_cyc);
      chk($sformatf("v%0d_timeout", i), 32'(stall_timeout), 32'(vecs[i].e_to));
    end

    // Eight consecutive IF stalls reach the limit; timeout is sticky.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(4'b0001, 32'h0, 32'h0);
      #1;
      chk($sformatf("run%0d_timeout", k), 32'(stall_timeout), 32'h0);
    end
    @(negedge clk);
    drive(4'b0000, 32'h0, 32'h0);
    #1;
    chk("limit_timeout", 32'(stall_timeout), 32'h1);
    chk("limit_cycles",  stall_cycles,       32'd21);
    @(negedge clk); @(negedge clk);
    #1;
    chk("sticky_timeout", 32'(stall_timeout), 32'h1);
    chk("idle_cycles",    stall_cycles,       32'd21);

    // Exception during outstanding access, then reset in the middle of DRAIN.
    @(negedge clk);
    drive(4'b1000, 32'h4, 32'h0);
    #1;
    chk("drain_enter_stall", 32'(stall), 32'h1F);
    chk("drain_enter_flush", 32'(flush), 32'h0);
    @(negedge clk);
    drive(4'b1000, 32'h0, 32'h0);
    #1;
    chk("drain_stall", 32'(stall), 32'h1F);
    #1 rst = 1'b1;
    #1;
    chk("midrst_stall",   32'(stall),         32'h0);
    chk("midrst_flush",   32'(flush),         32'h0);
    chk("midrst_timeout", 32'(stall_timeout), 32'h0);
    chk("midrst_cycles",  stall_cycles,       32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 32'h0, 32'h0);
    #1;
    chk("post_rst_flush",  32'(flush), 32'h0);
    chk("post_rst_new_pc", new_pc,     32'h0);
    @(negedge clk);
    #1;
    chk("post_rst_flush2", 32'(flush), 32'h0);
    chk("post_rst_stall2", 32'(stall), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
